water_flow_sequencer: RTL
=========================

# water_flow_sequencer

Position sequencer for the water-flow LED mode. Generates the one-hot `led_select` word consumed by the mode-3 PWM trail driver: it advances the lit head position at a programmable rate, in left, right or ping-pong order, with run, pause and single-step control. It sits between the mode/key control logic and the LED PWM driver.

## Interface
- `STEP_DIV`, 12_000_000: clock cycles per step at `speed`=0. 32-bit value.
- `N_LED`, 8: number of LED positions, which is also the width of `led_select`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `en`  in  1  sequencer enable. Level-sensitive.
- `pause`  in  1  freeze the position and the step counter. Level-sensitive.
- `step_req`  in  1  one-cycle pulse requesting a manual step. Honoured only in PAUSE.
- `dir_mode`  in  2  00 = left (LSB→MSB), 01 = right, 10 = ping-pong, 11 = hold.
- `speed`  in  2  step period = `STEP_DIV >> speed`, clamped to a minimum of 1.
- `led_select`  out  N_LED  one-hot head position. All zeros in IDLE.
- `step_strobe`  out  1  one-cycle pulse in the same cycle `led_select` takes a new value.
- `wrap`  out  1  one-cycle pulse on lap completion. Coincides with `step_strobe`.
- `busy`  out  1  high in RUN or PAUSE.

## Operation
- State machine has three states:
  - IDLE: `led_select`=0, counter held at 0.
  - RUN: counter increments each cycle.
  - PAUSE: counter and `led_select` are frozen.
- State transitions:
  - `en`=0 in any state → IDLE on the next edge, and `led_select` returns to 0. This has the highest priority.
  - IDLE with `en`=1 → RUN. `led_select`=1 (bit 0), counter=0, internal ping-pong direction = up. No strobe on this entry.
  - RUN with `pause`=1 → PAUSE. The counter value is preserved.
  - PAUSE with `pause`=0 → RUN. Counting resumes from the frozen value. Any `step_req` in that cycle is ignored.
  - PAUSE with `pause`=1 and `step_req`=1 → one step on the next edge, with `step_strobe` (and `wrap` if applicable). State stays PAUSE.
- Step in RUN:
  - When counter == period−1: counter ← 0 and the position advances per `dir_mode`.
  - Otherwise: counter ← counter+1.
- Step rules per `dir_mode`:
  - Left: rotate left. Bit N_LED−1 → bit 0, and `wrap` pulses on that step.
  - Right: rotate right. Bit 0 → bit N_LED−1, and `wrap` pulses on that step.
  - Ping-pong: move one position in the internal direction.
    - At bit N_LED−1, the direction becomes down and the next position is N_LED−2.
    - At bit 0, the direction becomes up and the next position is bit 1.
    - `wrap` pulses on the step that leaves bit 0 after a downward run, i.e. once per full bounce.
  - Hold: no position change, no `step_strobe`. The counter keeps wrapping.
- `dir_mode` and `speed` are sampled at every counter comparison.
  - A `speed` change takes effect immediately.
  - If the counter is already ≥ the new period−1, the next cycle steps and clears the counter.
- Period arithmetic is 32-bit unsigned. `STEP_DIV >> speed` equal to 0 is treated as 1, which means a step every cycle.
- Invariant: `led_select` is exactly one-hot whenever `busy`=1.

## Timing
- Reset values: `led_select`=0, `step_strobe`=0, `wrap`=0, `busy`=0, state IDLE, counter 0, direction up.
- All outputs are registered.
- `en` rise to `busy`=1 and `led_select`=1 takes 1 cycle.
- `en`=1 to first step takes 1 + period cycles: entry occurs at edge k, and the first strobe at edge k+period.
- In RUN, consecutive `step_strobe` pulses are exactly `period` cycles apart.
- `step_req` to strobe in PAUSE takes 1 cycle.
- Back-to-back `step_req` pulses on consecutive cycles each produce a step.
- Reset asserted mid-operation clears everything asynchronously.
- After `rst` drops, the block waits for `en`=1 sampled at a clock edge.

## Configuration
- `WFS_PINGPONG_EN` defined: `dir_mode`=10 gives ping-pong as specified, including the direction register.
- `WFS_PINGPONG_EN` undefined: `dir_mode`=10 behaves identically to 00 (left rotation, wrap at MSB→LSB). No direction register is built.

## Test plan
- Basic run: `STEP_DIV`=8, `speed`=0, left, `en` rising at cycle 10 → `led_select`=0x01 at 11, 0x02 at 19, 0x04 at 27, …, 0x80 at 67, 0x01 with `wrap`=1 at 75.
- Speed and right mode: `speed`=2 (period 2), right → sequence 0x01, 0x80, 0x40, …, strobes every 2 cycles, `wrap` on the 0x01→0x80 step. `speed`=3 gives period 1 (`STEP_DIV`>>3 = 1), strobing every cycle.
- Ping-pong (macro on): positions 0x01, 0x02, …, 0x80, 0x40, …, 0x01, 0x02. `wrap` occurs once, on the 0x01→0x02 step after the bounce. With the macro off, the same stimulus yields pure left rotation.
- Pause and step:
  - `pause`=1 with counter at 5 → counter and `led_select` frozen.
  - Three `step_req` pulses → three strobes, each 1 cycle after its pulse.
  - Releasing `pause` → next strobe 3 cycles later (counter resumes at 5, period 8).
- Disable and reset mid-run:
  - `en`=0 → `led_select`=0 and `busy`=0 next cycle.
  - Re-enabling restarts at 0x01.
  - `rst` pulse mid-step asynchronously zeroes all outputs.
- Hold mode: `dir_mode`=11 for 40 cycles → `led_select` unchanged, no `step_strobe` and no `wrap`. Returning to left resumes stepping on counter wrap.

Source files
------------

// File: rtl/water_flow_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : water_flow_sequencer                                          |
// | Function : One-hot head-position sequencer for the water-flow LED mode.  |
// |            Steps left, right, ping-pong or holds at a programmable rate, |
// |            with run / pause / single-step control.                       |
// | Options  : WFS_PINGPONG_EN - when defined, dir_mode=10 bounces between   |
// |            the end positions; when undefined it behaves as left rotation |
// |            and no direction register is built.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module water_flow_sequencer #(
  parameter logic [31:0] STEP_DIV = 32'd12_000_000,
  parameter int unsigned N_LED    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pause,
  input  logic             step_req,
  input  logic [1:0]       dir_mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led_select,
  output logic             step_strobe,
  output logic             wrap,
  output logic             busy
);

  localparam logic [N_LED-1:0] c_led_first = N_LED'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_cnt;
  logic [31:0]      w_cnt_nxt;
  logic [N_LED-1:0] r_led;
  logic [N_LED-1:0] w_led_nxt;
  logic             r_strobe;
  logic             w_strobe_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  // Step period: STEP_DIV >> speed, never below one cycle.
  logic [31:0]      w_shifted;
  logic [31:0]      w_period;
  logic [31:0]      w_last;

  // Candidate position for a step taken this cycle.
  logic [N_LED-1:0] w_step_led;
  logic             w_step_wrap;
  logic             w_step_move;
  logic             w_take_step;

`ifdef WFS_PINGPONG_EN
  logic             r_dir_down;
  logic             w_dir_nxt;
  logic             w_step_dir_down;
`endif

  assign w_shifted = STEP_DIV >> speed;
  assign w_period  = (w_shifted == 32'd0) ? 32'd1 : w_shifted;
  assign w_last    = w_period - 32'd1;

  // Compute where the head moves to if a step happens now, and whether that step closes a lap.
  always_comb begin
    w_step_led  = r_led;
    w_step_wrap = 1'b0;
    w_step_move = 1'b1;
`ifdef WFS_PINGPONG_EN
    w_step_dir_down = r_dir_down;
`endif
    case (dir_mode)
      2'b01: begin
        w_step_led  = (r_led >> 1) | (r_led << (N_LED - 1));
        w_step_wrap = r_led[0];
      end
      2'b11: begin
        w_step_move = 1'b0;
      end
`ifdef WFS_PINGPONG_EN
      2'b10: begin
        if (r_led[N_LED-1]) begin
          w_step_dir_down = 1'b1;
          w_step_led      = r_led >> 1;
        end else if (r_led[0]) begin
          // A lap ends when the head turns around at bit 0 after descending.
          w_step_dir_down = 1'b0;
          w_step_led      = r_led << 1;
          w_step_wrap     = r_dir_down;
        end else if (r_dir_down) begin
          w_step_led = r_led >> 1;
        end else begin
          w_step_led = r_led << 1;
        end
      end
`endif
      default: begin
        w_step_led  = (r_led << 1) | (r_led >> (N_LED - 1));
        w_step_wrap = r_led[N_LED-1];
      end
    endcase
  end

  // Next-state, counter and output decode; disable overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_led_nxt    = r_led;
    w_strobe_nxt = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_take_step  = 1'b0;
`ifdef WFS_PINGPONG_EN
    w_dir_nxt    = r_dir_down;
`endif
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 32'd0;
      w_led_nxt   = '0;
`ifdef WFS_PINGPONG_EN
      w_dir_nxt   = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 32'd0;
          w_led_nxt   = c_led_first;
`ifdef WFS_PINGPONG_EN
          w_dir_nxt   = 1'b0;
`endif
        end
        S_RUN: begin
          if (pause) begin
            w_state_nxt = S_PAUSE;
          end else if (r_cnt >= w_last) begin
            // ">=" so a speed increase that lands below the count steps at once.
            w_cnt_nxt   = 32'd0;
            w_take_step = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            w_state_nxt = S_RUN;
          end else if (step_req) begin
            w_take_step = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 32'd0;
          w_led_nxt   = '0;
        end
      endcase
    end

    if (w_take_step && w_step_move) begin
      w_led_nxt    = w_step_led;
      w_strobe_nxt = 1'b1;
      w_wrap_nxt   = w_step_wrap;
`ifdef WFS_PINGPONG_EN
      w_dir_nxt    = w_step_dir_down;
`endif
    end
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 32'd0;
      r_led      <= '0;
      r_strobe   <= 1'b0;
      r_wrap     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef WFS_PINGPONG_EN
      r_dir_down <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_led      <= w_led_nxt;
      r_strobe   <= w_strobe_nxt;
      r_wrap     <= w_wrap_nxt;
      r_busy     <= w_busy_nxt;
`ifdef WFS_PINGPONG_EN
      r_dir_down <= w_dir_nxt;
`endif
    end
  end

  assign led_select  = r_led;
  assign step_strobe = r_strobe;
  assign wrap        = r_wrap;
  assign busy        = r_busy;

endmodule
`default_nettype wire
